bus_arbiter: RTL
================

# bus_arbiter

- Round-robin arbiter sharing one 8-bit tristate write bus between `NUM_REQ` writer blocks.
- Each writer raises its request and holds it while its busy line is high; its value appears on the bus only while it sees busy low.
- The arbiter drops exactly one writer's busy line for one cycle, captures the bus into a registered output and forwards it downstream with a valid pulse.
- It sits between the writer instances and the downstream consumer (sink/logger).

## Interface

Parameters:
- `NUM_REQ`, 4, number of requesters, 2..16
- `DATA_W`, 8, shared bus width
- `ID_W`, `$clog2(NUM_REQ)`, requester index width (derived, not overridden)

Ports:
- `i_clk`  in  1  clock; all logic on rising edge
- `i_reset`  in  1  reset, synchronous, active-high
- `i_req`  in  NUM_REQ  per-writer request, bit i = writer i
- `o_busy`  out  NUM_REQ  per-writer busy, registered; 0 = "drive bus now"
- `i_bus`  in  DATA_W  shared tristate bus (resolved net)
- `o_data`  out  DATA_W  captured word, registered
- `o_valid`  out  1  one-cycle pulse, `o_data`/`o_id` valid
- `o_id`  out  ID_W  index of writer that produced `o_data`
- `o_err`  out  1  one-cycle pulse: granted writer still requesting in RELEASE

## Operation

- State machine `state`: IDLE, GRANT, RELEASE.
- Round-robin pointer `last` (ID_W bits) holds the last granted index.
- IDLE:
  - If `|i_req`, the winner is the first set bit scanning `last+1, last+2, …` with wrap modulo NUM_REQ.
  - On a win: `grant<=winner`, `last<=winner`, `o_busy<=~(1<<winner)`, go GRANT.
  - Otherwise stay in IDLE, `o_busy` all ones.
- GRANT (exactly 1 cycle):
  - Capture `o_data<=i_bus`, `o_id<=grant`, `o_valid<=1`.
  - Set `o_busy<=all ones` and go RELEASE.
  - The capture happens even if `i_req[grant]` has fallen; no data qualification.
- RELEASE (exactly 1 cycle):
  - Gives the writer one cycle to drop its request and tristate.
  - If `i_req[grant]` is still 1, pulse `o_err`.
  - Always go IDLE. The request is re-arbitrated fairly because `last` already points at it.
- Only one bit of `o_busy` is ever 0, and never for more than one consecutive cycle. Busy is never low for a non-requesting writer at grant time.
- Simultaneous requests: strict round-robin. A writer with its request held continuously waits at most NUM_REQ−1 grants.
- Requests arriving during GRANT or RELEASE are only seen in IDLE. No request is lost, because writers hold requests until served.
- Reset values: state IDLE, `last=NUM_REQ-1` (writer 0 has first priority), `grant=0`, `o_busy` all ones, `o_data=0`, `o_valid=0`, `o_id=0`, `o_err=0`.
- Reset mid-operation (any state): on the next edge all of the above reset values apply. An in-flight capture is discarded and `o_valid` stays 0.

## Timing

- Edge k: IDLE sees the request. Cycle k+1: GRANT, `o_busy[g]=0`.
- Edge k+1 end: writer samples busy=0 and clears its request; arbiter samples `i_bus`.
- Cycle k+2: RELEASE, `o_valid=1`, `o_data`/`o_id` valid.
- Cycle k+3: IDLE. The earliest next grant is visible at cycle k+4.
- Throughput: one word per 3 cycles.
- Request-seen to `o_valid` latency: 2 cycles.
- `o_valid` and `o_err` are never high for two consecutive cycles.

## Structure

- Shared package `bus_arb_pkg`:
  - state encodings ST_IDLE=0, ST_GRANT=1, ST_RELEASE=2
  - state width 2
  - DATA_W default 8
- Combinational sub-module `rr_pick`:
  - inputs `req[NUM_REQ]`, `last[ID_W]`
  - outputs `winner[ID_W]`, `any`
  - implemented as a rotate, fixed-priority encode, then un-rotate
- Formal properties:
  - `$onehot0(~o_busy)`
  - `o_busy` low ⇒ `$past(state)==ST_IDLE`
  - state < 3
  - a held request is granted within 3·NUM_REQ cycles

## Test plan

- Reset, no requests, 20 cycles -> `o_busy=4'b1111`, `o_valid` never high, `o_err` never high.
- Single writer 2 drives bus 8'h05 and requests at cycle 10 -> `o_busy=4'b1011` at cycle 11; cycle 12 `o_valid=1`, `o_data=8'h05`, `o_id=2`.
- All four request continuously, each drives its index -> `o_id` sequence 0,1,2,3,0,… with `o_valid` every 3rd cycle.
- Writers 1 and 3 request, then writer 0 requests during writer 1's GRANT -> grant order 1,3,0.
- Writer 1 granted but holds request through RELEASE -> `o_err` pulses in RELEASE; next grant goes to any other requester before 1.
- `i_reset` asserted during GRANT -> next cycle state IDLE, `o_busy` all ones, no `o_valid` pulse.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin write-bus arbiter.
package bus_arb_pkg;

    localparam int unsigned STATE_W        = 2;
    localparam int unsigned DATA_W_DEFAULT = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: rotate so last+1 sits at bit 0, fixed-priority
// encode, then rotate the found offset back into a requester index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any
);

    logic [ID_W-1:0]    w_shift;
    logic [ID_W-1:0]    w_off;
    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W:0]      w_sum;

    always_comb begin
        w_shift = (i_last == ID_W'(NUM_REQ - 1)) ? '0 : i_last + 1'b1;
        w_rot   = NUM_REQ'({i_req, i_req} >> w_shift);
        w_off   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = ID_W'(j);
            end
        end
        // Un-rotate modulo NUM_REQ, which need not be a power of two.
        w_sum = {1'b0, w_shift} + {1'b0, w_off};
        if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
        end
        o_winner = w_sum[ID_W-1:0];
        o_any    = |i_req;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared tristate write bus: grants one writer per
// three cycles by dropping its busy line, captures the bus and forwards it.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DATA_W_DEFAULT,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_busy,
    input  logic [DATA_W-1:0]  i_bus,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id,
    output logic               o_err
);

    state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_last, w_last_nxt;
    logic [ID_W-1:0]    r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_busy, w_busy_nxt;
    logic [DATA_W-1:0]  r_data, w_data_nxt;
    logic [ID_W-1:0]    r_id, w_id_nxt;
    logic               r_valid, w_valid_nxt;
    logic [ID_W-1:0]    w_winner;
    logic               w_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_last  <= ID_W'(NUM_REQ - 1);
            r_grant <= '0;
            r_busy  <= '1;
            r_data  <= '0;
            r_id    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= w_busy_nxt;
            r_data  <= w_data_nxt;
            r_id    <= w_id_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_busy_nxt  = '1;
        w_data_nxt  = r_data;
        w_id_nxt    = r_id;
        w_valid_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_winner;
                    w_last_nxt  = w_winner;
                    w_busy_nxt  = ~(NUM_REQ'(1) << w_winner);
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Capture unconditionally; the writer drives while it sees busy low.
                w_data_nxt  = i_bus;
                w_id_nxt    = r_grant;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A writer still requesting while released failed to drop after its grant.
    assign o_err   = (r_state == ST_RELEASE) && i_req[r_grant];
    assign o_busy  = r_busy;
    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_id    = r_id;

    a_busy_onehot0: assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0(~o_busy));
    a_busy_after_idle: assert property (@(posedge i_clk) disable iff (i_reset)
        !(&o_busy) |-> $past(r_state) == ST_IDLE);
    a_state_legal: assert property (@(posedge i_clk) disable iff (i_reset)
        r_state <= ST_RELEASE);

endmodule
